// File: rtl/reg_bank_mp.sv
// Multi-port ARMv8 general-purpose register file: NUM_RD combinational read ports,
// two write ports with optional write-through bypass, W-write zero extension and a busy scoreboard.
module reg_bank_mp #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 3,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic [NUM_RD*ADDR_W-1:0]   rdAddr,
  output logic [NUM_RD*DATA_W-1:0]   rdData,
  output logic [NUM_RD-1:0]          rdBusy,
  input  logic                       wrEn0,
  input  logic [ADDR_W-1:0]          wrAddr0,
  input  logic [DATA_W-1:0]          wrData0,
  input  logic                       wrW0,
  input  logic                       wrEn1,
  input  logic [ADDR_W-1:0]          wrAddr1,
  input  logic [DATA_W-1:0]          wrData1,
  input  logic                       wrW1,
  input  logic                       busySet,
  input  logic [ADDR_W-1:0]          busySetAddr
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  // An address is usable only if it is in range and is not the hardwired zero register.
  function automatic logic validAddr(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(NUM_REGS)) && (a != ZERO_A);
  endfunction

  logic [DATA_W-1:0] regMem  [NUM_REGS];
  logic              busyReg [NUM_REGS];

  logic              wr0Ok, wr1Ok, setOk;
  logic [DATA_W-1:0] ext0, ext1;

  assign wr0Ok = wrEn0 && validAddr(wrAddr0);
  assign wr1Ok = wrEn1 && validAddr(wrAddr1);
  assign setOk = busySet && validAddr(busySetAddr);
  assign ext0  = wrW0 ? {{(DATA_W-32){1'b0}}, wrData0[31:0]} : wrData0;
  assign ext1  = wrW1 ? {{(DATA_W-32){1'b0}}, wrData1[31:0]} : wrData1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : gReg
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
      logic hit0, hit1;
      assign hit0 = wr0Ok && (wrAddr0 == IDX);
      assign hit1 = wr1Ok && (wrAddr1 == IDX);

      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
          regMem[gi]  <= '0;
          busyReg[gi] <= 1'b0;
        end else begin
          if (hit1)
            regMem[gi] <= ext1;
          else if (hit0)
            regMem[gi] <= ext0;
          // A new producer issued this cycle outranks the retiring one.
          if (setOk && (busySetAddr == IDX))
            busyReg[gi] <= 1'b1;
          else if (hit0 || hit1)
            busyReg[gi] <= 1'b0;
        end
      end
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : gRd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              busy, byp0, byp1;

      assign addr = rdAddr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        data = '0;
        busy = 1'b0;
        byp0 = (BYPASS != 0) && wr0Ok && (wrAddr0 == addr);
        byp1 = (BYPASS != 0) && wr1Ok && (wrAddr1 == addr);
        // Gating on rstN keeps bypassed write data from leaking out during reset.
        if (rstN && validAddr(addr)) begin
          data = regMem[addr];
          busy = busyReg[addr];
          if (byp1)
            data = ext1;
          else if (byp0)
            data = ext0;
          if ((byp0 || byp1) && !(setOk && (busySetAddr == addr)))
            busy = 1'b0;
        end
      end

      assign rdData[gi*DATA_W +: DATA_W] = data;
      assign rdBusy[gi]                  = busy;
    end
  endgenerate

endmodule
